dmem_access_unit: RTL and testbench
===================================

// Module: dmem_access_unit
// PURPOSE
//  CPU-side initiator for the word-wide data memory (async read, write on clk edge when wena).
//  Takes one load/store request at a time from the MEM stage and performs LB/LBU/LH/LHU/LW/SB/SH/SW.
//  Sub-word stores use a read-modify-write sequence because the memory only writes full words.
//  Checks alignment and address range, and returns sign/zero-extended load data with a done pulse.
// PARAMETERS
//  BASE_ADDR    32'h1001_0000  byte address of data-memory word 0
//  DEPTH_WORDS  1024           number of 32-bit words in data memory
// PORTS
//  clk          in   1   system clock, all state changes on posedge
//  rst          in   1   synchronous reset, active-high
//  req_valid    in   1   request present; accepted when req_valid & req_ready
//  req_ready    out  1   1 only in IDLE
//  req_op       in   3   0 LB,1 LBU,2 LH,3 LHU,4 LW,5 SB,6 SH,7 SW
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data; SB uses [7:0], SH uses [15:0]
//  done         out  1   one-cycle pulse, request finished
//  err          out  1   valid with done; 1 = misaligned or out-of-range, no memory write done
//  rdata        out  32  load result, valid with done and held until next done
//  dmem_wena    out  1   memory write enable
//  dmem_addr    out  32  word-aligned byte address {addr[31:2],2'b00}
//  dmem_wdata   out  32  memory write data
//  dmem_rdata   in   32  memory read data, combinational from dmem_addr
// BEHAVIOUR
//  Reset values
//   - state=IDLE, done=0, err=0, rdata=0, dmem_wena=0, dmem_addr=BASE_ADDR, dmem_wdata=0
//  FSM: IDLE, ACCESS, WRITE, DONE
//   - IDLE: on accept, latch op/addr/wdata and compute err.
//     - err=1 if LH/LHU/SH with addr[0]!=0, or LW/SW with addr[1:0]!=0.
//     - err=1 if addr<BASE_ADDR or (addr-BASE_ADDR)>>2 >= DEPTH_WORDS (32-bit unsigned compare).
//     - If err, go to DONE. Otherwise go to ACCESS.
//   - ACCESS (cycle 1): dmem_addr is driven from the latched addr.
//     - Load: extract the byte/half at addr[1:0] from dmem_rdata (little-endian: byte0=[7:0]).
//       Sign-extend for LB/LH, zero-extend for LBU/LHU. Register the result into rdata, then go to DONE.
//     - SW: dmem_wena=1, dmem_wdata=wdata, then go to DONE.
//     - SB/SH: merge the new byte/half into dmem_rdata at addr[1:0], register the merged word, go to WRITE.
//   - WRITE (cycle 2): dmem_wena=1, dmem_wdata=merged word, dmem_addr unchanged, then go to DONE.
//   - DONE: done=1 for exactly one cycle, err valid, then go to IDLE.
//  Latency from accept edge to done:
//   - Error: 1 cycle.
//   - Loads and SW: 2 cycles.
//   - SB/SH: 3 cycles.
//  req_valid is ignored outside IDLE. A request held valid is accepted again in the cycle after done.
//  dmem_wena is never 1 while rst=1: it is gated combinationally by ~rst.
//  Reset mid-operation: abandon the request, no partial write, no done pulse.
//  rdata is updated only by successful loads. Stores and errors leave it unchanged.
//  Only addresses already range-checked are ever written.
// TESTING
//  - LW at BASE+0x8 (mem word 0xDEADBEEF): done at cycle 2, rdata=0xDEADBEEF, err=0, no wena.
//  - LB at BASE+0x3, then LBU at BASE+0x3, word 0x80112233: rdata=0xFFFFFF80, then 0x00000080.
//  - SB 0xAA at BASE+0x1 over word 0x11223344: wena only in WRITE, memory=0x1122AA44, done at cycle 3.
//  - LH at BASE+0x1, SW at BASE+0x2, LW at BASE-4, LW at BASE+4*DEPTH_WORDS:
//    each gives done+err at cycle 1, no wena, rdata unchanged.
//  - rst asserted during WRITE of SH: wena=0 that cycle, memory unchanged, IDLE next, req_ready=1.
//  - Back-to-back: SW 0x12345678 then LW at the same address with req_valid held:
//    second request accepted the cycle after done, returns 0x12345678.

Source files
------------

// File: rtl/dmem_access_unit.sv
// dmem_access_unit
// CPU-side initiator for a word-wide data memory. The memory reads
// asynchronously and writes a full word on the clock edge when wena is high.
// One load/store request is handled at a time. Sub-word stores are done as
// read-modify-write because the memory only writes full words.
//
// Ports
//   clk, rst     system clock, synchronous active-high reset
//   req_valid    request present (accepted when req_valid & req_ready)
//   req_ready    high only while idle
//   req_op       0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 SB, 6 SH, 7 SW
//   req_addr     byte address
//   req_wdata    store data (SB uses [7:0], SH uses [15:0])
//   done         one-cycle completion pulse
//   err          valid with done: misaligned or out-of-range, nothing written
//   rdata        load result, held until the next successful load
//   dmem_wena    memory write enable (forced low while rst is high)
//   dmem_addr    word-aligned byte address to memory
//   dmem_wdata   memory write data
//   dmem_rdata   memory read data, combinational from dmem_addr
module dmem_access_unit #(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int          DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        dmem_wena,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata
);

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LBU = 3'd1;
  localparam logic [2:0] OP_LH  = 3'd2;
  localparam logic [2:0] OP_LHU = 3'd3;
  localparam logic [2:0] OP_LW  = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  localparam logic [31:0] DEPTH_W = 32'(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, DONE} state_t;

  state_t      state;
  logic [2:0]  op_q;
  logic [1:0]  byte_off;
  logic [15:0] wdata_lo;
  logic        wena_q;

  logic [31:0] offset;
  logic        misaligned;
  logic        out_of_range;
  logic        req_err;
  logic [4:0]  shamt;
  logic [15:0] lane;
  logic [31:0] load_value;
  logic [31:0] ins_mask;
  logic [31:0] ins_data;
  logic [31:0] merged;

  assign req_ready = (state == IDLE);
  assign dmem_wena = wena_q & ~rst;

  // Request checks on the incoming address, evaluated in IDLE at accept time.
  always_comb begin
    offset       = req_addr - BASE_ADDR;
    out_of_range = (req_addr < BASE_ADDR) || ((offset >> 2) >= DEPTH_W);
    misaligned   = 1'b0;
    case (req_op)
      OP_LH, OP_LHU, OP_SH: misaligned = req_addr[0];
      OP_LW, OP_SW:         misaligned = |req_addr[1:0];
      default:              misaligned = 1'b0;
    endcase
    req_err = misaligned | out_of_range;
  end

  // Lane extraction for loads and lane insertion for sub-word stores,
  // both driven by the latched byte offset against the live memory word.
  always_comb begin
    shamt      = {byte_off, 3'b000};
    lane       = 16'(dmem_rdata >> shamt);
    load_value = dmem_rdata;
    case (op_q)
      OP_LB:   load_value = {{24{lane[7]}}, lane[7:0]};
      OP_LBU:  load_value = {24'h0, lane[7:0]};
      OP_LH:   load_value = {{16{lane[15]}}, lane};
      OP_LHU:  load_value = {16'h0, lane};
      default: load_value = dmem_rdata;
    endcase
    if (op_q == OP_SB) begin
      ins_mask = 32'h0000_00FF << shamt;
      ins_data = {24'h0, wdata_lo[7:0]} << shamt;
    end else begin
      ins_mask = 32'h0000_FFFF << shamt;
      ins_data = {16'h0, wdata_lo} << shamt;
    end
    merged = (dmem_rdata & ~ins_mask) | ins_data;
  end

  // Control FSM. All outputs are registered; done and wena default low so
  // they only pulse in the cycle the state explicitly asks for them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      done       <= 1'b0;
      err        <= 1'b0;
      rdata      <= 32'h0;
      wena_q     <= 1'b0;
      dmem_addr  <= BASE_ADDR;
      dmem_wdata <= 32'h0;
      op_q       <= 3'd0;
      byte_off   <= 2'd0;
      wdata_lo   <= 16'h0;
    end else begin
      done   <= 1'b0;
      wena_q <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q     <= req_op;
            byte_off <= req_addr[1:0];
            wdata_lo <= req_wdata[15:0];
            err      <= req_err;
            if (req_err) begin
              // Bad requests never touch dmem_addr, so no unchecked
              // address is ever presented with wena.
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= ACCESS;
              dmem_addr <= {req_addr[31:2], 2'b00};
              // SW needs no read, so its write is issued during ACCESS.
              if (req_op == OP_SW) begin
                wena_q     <= 1'b1;
                dmem_wdata <= req_wdata;
              end
            end
          end
        end
        ACCESS: begin
          if (op_q <= OP_LW) begin
            rdata <= load_value;
            state <= DONE;
            done  <= 1'b1;
          end else if (op_q == OP_SW) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            dmem_wdata <= merged;
            wena_q     <= 1'b1;
            state      <= WRITE;
          end
        end
        WRITE: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          err   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit
// Directed bench for dmem_access_unit. Requests are issued from the main
// process, which pushes the expected completion into a scoreboard queue;
// a separate monitor pops and compares whenever done is seen.
module tb_dmem_access_unit;

  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int          DEPTH = 1024;

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LBU = 3'd1;
  localparam logic [2:0] OP_LH  = 3'd2;
  localparam logic [2:0] OP_LHU = 3'd3;
  localparam logic [2:0] OP_LW  = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic        dmem_wena;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          wena_n;
    int          wena_at;
  } exp_t;

  exp_t        sb[$];
  int          checks;
  int          failures;
  int          cycle;
  int          accept_cycle;
  int          last_done_cycle;
  int          wena_n;
  int          wena_at;
  logic        prev_done;
  logic [31:0] model_rdata;

  logic [31:0] mem [0:DEPTH-1];
  logic        bd_we;
  int          bd_idx;
  logic [31:0] bd_data;

  dmem_access_unit #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .done       (done),
    .err        (err),
    .rdata      (rdata),
    .dmem_wena  (dmem_wena),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic in_range(input logic [31:0] a);
    return (a >= BASE) && (((a - BASE) >> 2) < 32'(DEPTH));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  // Memory model: asynchronous read, write on the rising edge.
  assign dmem_rdata = in_range(dmem_addr) ? mem[widx(dmem_addr)] : 32'h0;

  always @(posedge clk) begin
    if (dmem_wena) begin
      if (in_range(dmem_addr)) mem[widx(dmem_addr)] <= dmem_wdata;
    end else if (bd_we) begin
      mem[bd_idx] <= bd_data;
    end
  end

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (!rst && req_valid && req_ready) accept_cycle <= cycle;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: tracks write-enable activity and scores each done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (dmem_wena) begin
      wena_n++;
      wena_at = cycle - accept_cycle;
    end
    if (done) begin
      checkOutput("done_pulse_width", {31'h0, prev_done}, 32'h0);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_done actual=1 expected=0");
      end else begin
        e = sb.pop_front();
        checkOutput("err", {31'h0, err}, {31'h0, e.err});
        checkOutput("rdata", rdata, e.rdata);
        checkOutput("latency", 32'(cycle - accept_cycle), 32'(e.lat));
        checkOutput("wena_count", 32'(wena_n), 32'(e.wena_n));
        if (e.wena_n != 0) checkOutput("wena_cycle", 32'(wena_at), 32'(e.wena_at));
      end
      wena_n = 0;
      wena_at = 0;
      last_done_cycle = cycle;
    end
    prev_done = done;
  end

  task automatic preload(input int idx, input logic [31:0] data);
    @(negedge clk);
    bd_we   = 1'b1;
    bd_idx  = idx;
    bd_data = data;
    @(posedge clk);
    #1 bd_we = 1'b0;
  endtask

  task automatic pushExpected(input logic [2:0] op, input logic e_err, input logic [31:0] e_load);
    exp_t e;
    e.err = e_err;
    if (e_err) begin
      e.lat = 1; e.wena_n = 0; e.wena_at = 0;
    end else if (op <= OP_LW) begin
      e.lat = 2; e.wena_n = 0; e.wena_at = 0;
      model_rdata = e_load;
    end else if (op == OP_SW) begin
      e.lat = 2; e.wena_n = 1; e.wena_at = 1;
    end else begin
      e.lat = 3; e.wena_n = 1; e.wena_at = 2;
    end
    e.rdata = model_rdata;
    sb.push_back(e);
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) return;
    end
    checks++;
    failures++;
    $display("[TB] FAIL done_timeout actual=pending expected=done");
    sb.delete();
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic e_err, input logic [31:0] e_load);
    bit seen;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (req_ready) seen = 1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("[TB] FAIL ready_timeout actual=0 expected=1");
    end
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    pushExpected(op, e_err, e_load);
    @(posedge clk);
    #1 req_valid = 1'b0;
    waitIdle();
  endtask

  initial begin
    int d1;
    checks = 0; failures = 0; cycle = 0; accept_cycle = 0; last_done_cycle = 0;
    wena_n = 0; wena_at = 0; prev_done = 1'b0; model_rdata = 32'h0;
    bd_we = 1'b0; bd_idx = 0; bd_data = 32'h0;
    rst = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", {31'h0, req_ready}, 32'h1);
    checkOutput("rst_done", {31'h0, done}, 32'h0);
    checkOutput("rst_err", {31'h0, err}, 32'h0);
    checkOutput("rst_rdata", rdata, 32'h0);
    checkOutput("rst_wena", {31'h0, dmem_wena}, 32'h0);
    checkOutput("rst_addr", dmem_addr, BASE);
    checkOutput("rst_wdata", dmem_wdata, 32'h0);
    rst = 1'b0;

    preload(2, 32'hDEAD_BEEF);
    preload(0, 32'h8011_2233);
    preload(1023, 32'h0BAD_CAFE);
    preload(4, 32'hCAFE_F00D);

    $display("[TB] loads");
    applyStimulus(OP_LW,  BASE + 32'h8, 32'h0, 1'b0, 32'hDEAD_BEEF);
    applyStimulus(OP_LB,  BASE + 32'h3, 32'h0, 1'b0, 32'hFFFF_FF80);
    applyStimulus(OP_LBU, BASE + 32'h3, 32'h0, 1'b0, 32'h0000_0080);
    applyStimulus(OP_LH,  BASE + 32'h2, 32'h0, 1'b0, 32'hFFFF_8011);
    applyStimulus(OP_LHU, BASE + 32'h0, 32'h0, 1'b0, 32'h0000_2233);
    applyStimulus(OP_LW,  BASE + 32'hFFC, 32'h0, 1'b0, 32'h0BAD_CAFE);

    $display("[TB] sub-word stores");
    preload(0, 32'h1122_3344);
    applyStimulus(OP_SB, BASE + 32'h1, 32'h0000_55AA, 1'b0, 32'h0);
    checkOutput("mem_after_sb", mem[0], 32'h1122_AA44);
    applyStimulus(OP_SH, BASE + 32'h2, 32'h1234_BEEF, 1'b0, 32'h0);
    checkOutput("mem_after_sh", mem[0], 32'hBEEF_AA44);
    applyStimulus(OP_LW, BASE + 32'h0, 32'h0, 1'b0, 32'hBEEF_AA44);

    $display("[TB] error cases");
    applyStimulus(OP_LH, BASE + 32'h1, 32'h0, 1'b1, 32'h0);
    applyStimulus(OP_SW, BASE + 32'h2, 32'hFFFF_FFFF, 1'b1, 32'h0);
    checkOutput("mem_after_bad_sw", mem[0], 32'hBEEF_AA44);
    applyStimulus(OP_LW, BASE - 32'h4, 32'h0, 1'b1, 32'h0);
    applyStimulus(OP_LW, BASE + 32'h1000, 32'h0, 1'b1, 32'h0);

    $display("[TB] reset during write");
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_SH; req_addr = BASE + 32'h12; req_wdata = 32'h0000_1234;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("wena_in_rst", {31'h0, dmem_wena}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_rdata = 32'h0;
    @(negedge clk);
    checkOutput("ready_after_rst", {31'h0, req_ready}, 32'h1);
    checkOutput("done_after_rst", {31'h0, done}, 32'h0);
    checkOutput("mem_after_rst", mem[4], 32'hCAFE_F00D);
    checkOutput("rdata_after_rst", rdata, 32'h0);

    $display("[TB] back-to-back");
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_SW; req_addr = BASE + 32'h20; req_wdata = 32'h1234_5678;
    pushExpected(OP_SW, 1'b0, 32'h0);
    waitIdle();
    d1 = last_done_cycle;
    req_op = OP_LW; req_wdata = 32'h0;
    pushExpected(OP_LW, 1'b0, 32'h1234_5678);
    waitIdle();
    req_valid = 1'b0;
    checkOutput("back_to_back_gap", 32'(last_done_cycle - d1), 32'd3);
    checkOutput("mem_after_sw", mem[8], 32'h1234_5678);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
